// File: rtl/dl2_backing_memory.sv
// Main-memory model behind the unified L2: block fills and writebacks streamed as sub-block beats.
// Optional macro MEMD_STATS_EN adds saturating read/write/busy statistics outputs.
`timescale 1ns/1ps
module dl2_backing_memory #(
  parameter int unsigned ADDR_BITS       = 32,
  parameter int unsigned BLOCK_BITS      = 256,
  parameter int unsigned SUBBLOCKS       = 4,
  parameter int unsigned MEM_BLOCKS_LOG2 = 12,
  parameter int unsigned READ_LATENCY    = 8,
  parameter int unsigned WRITE_LATENCY   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_BITS-1:0]              addr,
  input  logic                              en,
  input  logic                              we,
  input  logic [$clog2(SUBBLOCKS)-1:0]      wr_strobe,
  input  logic [BLOCK_BITS/SUBBLOCKS-1:0]   wr_data,
  output logic [$clog2(SUBBLOCKS)-1:0]      rd_strobe,
  output logic [BLOCK_BITS/SUBBLOCKS-1:0]   rd_data,
  output logic                              ready,
  output logic                              acc_r,
  output logic                              acc_w
`ifdef MEMD_STATS_EN
  ,
  output logic [31:0]                       stat_reads,
  output logic [31:0]                       stat_writes,
  output logic [31:0]                       stat_busy
`endif
);

  localparam int unsigned BEAT_W     = BLOCK_BITS / SUBBLOCKS;
  localparam int unsigned BEAT_IDX_W = $clog2(SUBBLOCKS);
  localparam int unsigned OFFSET_W   = $clog2(BLOCK_BITS / 8);
  localparam int unsigned IDX_W      = MEM_BLOCKS_LOG2;
  localparam int unsigned MEM_DEPTH  = 2 ** (IDX_W + BEAT_IDX_W);
  localparam int unsigned CNT_MAX_RW = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_MAX    = (CNT_MAX_RW > SUBBLOCKS) ? CNT_MAX_RW : SUBBLOCKS;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    RLAT,
    RBURST,
    WBURST,
    WCOMMIT
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BEAT_IDX_W-1:0]   beat_q, beat_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    ready_q, acc_r_q, acc_w_q;
  logic [BEAT_IDX_W-1:0]   rd_strobe_q;
  logic [BEAT_W-1:0]       rd_data_q;
  logic                    accept_c;

  // Beat-granular backing store addressed as {block index, beat}; never cleared
  logic [BEAT_W-1:0]       mem_q [MEM_DEPTH];

  // Block offset and wrapped upper address bits do not select storage
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[OFFSET_W-1:0], addr[ADDR_BITS-1:OFFSET_W+IDX_W]};

  assign accept_c = (state_q == IDLE) && en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          idx_d  = addr[OFFSET_W +: IDX_W];
          cnt_d  = '0;
          beat_d = '0;
          if (we)                     state_d = WBURST;
          else if (READ_LATENCY <= 1) state_d = RBURST;
          else                        state_d = RLAT;
        end
      end
      RLAT: begin
        if (cnt_q == CNT_W'(READ_LATENCY - 2)) state_d = RBURST;
        else                                   cnt_d   = cnt_q + CNT_W'(1);
      end
      RBURST: begin
        if (beat_q == BEAT_IDX_W'(SUBBLOCKS - 1)) state_d = IDLE;
        else                                      beat_d  = beat_q + BEAT_IDX_W'(1);
      end
      WBURST: begin
        if (cnt_q == CNT_W'(SUBBLOCKS - 1)) begin
          cnt_d   = '0;
          state_d = (WRITE_LATENCY == 0) ? IDLE : WCOMMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WCOMMIT: begin
        if (cnt_q == CNT_W'(WRITE_LATENCY - 1)) state_d = IDLE;
        else                                    cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; read beats hold their last value outside a burst
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      idx_q       <= '0;
      ready_q     <= 1'b1;
      acc_r_q     <= 1'b0;
      acc_w_q     <= 1'b0;
      rd_strobe_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      ready_q <= (state_d == IDLE);
      acc_r_q <= (state_d == RBURST);
      acc_w_q <= (state_d == WBURST);
      if (state_d == RBURST) begin
        rd_strobe_q <= beat_d;
        rd_data_q   <= mem_q[{idx_d, beat_d}];
      end
    end
  end

  // Writeback beats land immediately; an aborting reset suppresses only the current beat
  always_ff @(posedge clk) begin
    if (!reset && (state_q == WBURST)) begin
      mem_q[{idx_q, wr_strobe}] <= wr_data;
    end
  end

  assign ready     = ready_q;
  assign acc_r     = acc_r_q;
  assign acc_w     = acc_w_q;
  assign rd_strobe = rd_strobe_q;
  assign rd_data   = rd_data_q;

`ifdef MEMD_STATS_EN
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  logic [31:0] stat_reads_q, stat_writes_q, stat_busy_q;

  // Saturating activity counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_busy_q   <= '0;
    end else begin
      if (accept_c && !we && (stat_reads_q != STAT_MAX)) stat_reads_q  <= stat_reads_q + 32'd1;
      if (accept_c && we && (stat_writes_q != STAT_MAX)) stat_writes_q <= stat_writes_q + 32'd1;
      if (!ready_q && (stat_busy_q != STAT_MAX))         stat_busy_q   <= stat_busy_q + 32'd1;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_busy   = stat_busy_q;
`else
  logic unused_accept;
  assign unused_accept = accept_c;
`endif

endmodule

// File: tb/tb_dl2_backing_memory.sv
// Randomized bench for dl2_backing_memory against a beat-level array model with fixed latency rules.
`timescale 1ns/1ps
module tb_dl2_backing_memory;

  localparam int unsigned RL = 8;
  localparam int unsigned WL = 4;
  localparam int unsigned SB = 4;

  logic        clk = 1'b0;
  logic        reset, en, we;
  logic [31:0] addr;
  logic [1:0]  wr_strobe, rd_strobe;
  logic [63:0] wr_data, rd_data;
  logic        ready, acc_r, acc_w;
`ifdef MEMD_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_busy;
`endif

  dl2_backing_memory dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .en        (en),
    .we        (we),
    .wr_strobe (wr_strobe),
    .wr_data   (wr_data),
    .rd_strobe (rd_strobe),
    .rd_data   (rd_data),
    .ready     (ready),
    .acc_r     (acc_r),
    .acc_w     (acc_w)
`ifdef MEMD_STATS_EN
    ,
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_busy   (stat_busy)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] model_mem [int];
  int unsigned exp_reads, exp_writes, exp_busy;
  logic [1:0]  hold_strobe;
  logic [63:0] hold_data;
  logic [63:0] d [SB];
  logic [1:0]  s [SB];
  int          blks [6];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int blk_of(input logic [31:0] a);
    return int'((a >> 5) & 32'h0000_0FFF);
  endfunction

  function automatic logic [31:0] addr_for(input int blk);
    return ($urandom & 32'hFFFE_0000) | (32'(blk) << 5) | ($urandom & 32'h1F);
  endfunction

  // Random en/we/addr while busy; must be ignored by the DUT
  task automatic busy_noise(input bit last);
    if (last) begin
      en = 1'b0;
    end else begin
      en   = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = $urandom;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_reads = 0; exp_writes = 0; exp_busy = 0;
    hold_strobe = '0; hold_data = '0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] dv [SB], input logic [1:0] sv [SB]);
    int blk;
    blk = blk_of(a);
    check_val("wr_ready_at_accept", 64'(ready), 64'd1);
    en = 1'b1; we = 1'b1; addr = a;
    @(negedge clk);
    exp_writes++;
    for (int i = 0; i < SB; i++) begin
      check_val("wr_acc_w_beat", 64'(acc_w), 64'd1);
      check_val("wr_acc_r_beat", 64'(acc_r), 64'd0);
      check_val("wr_ready_beat", 64'(ready), 64'd0);
      if (i == 0) begin
        check_val("wr_rd_strobe_hold", 64'(rd_strobe), 64'(hold_strobe));
        check_val("wr_rd_data_hold", rd_data, hold_data);
      end
      exp_busy++;
      wr_strobe = sv[i];
      wr_data   = dv[i];
      model_mem[blk * SB + int'(sv[i])] = dv[i];
      busy_noise((WL == 0) && (i == SB - 1));
      @(negedge clk);
    end
    for (int i = 0; i < WL; i++) begin
      check_val("wr_commit_acc_w", 64'(acc_w), 64'd0);
      check_val("wr_commit_ready", 64'(ready), 64'd0);
      exp_busy++;
      busy_noise(i == WL - 1);
      @(negedge clk);
    end
  endtask

  task automatic do_read(input logic [31:0] a);
    int blk;
    blk = blk_of(a);
    check_val("rd_ready_at_accept", 64'(ready), 64'd1);
    en = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    exp_reads++;
    for (int i = 0; i < RL - 1; i++) begin
      check_val("rd_lat_acc_r", 64'(acc_r), 64'd0);
      check_val("rd_lat_acc_w", 64'(acc_w), 64'd0);
      check_val("rd_lat_ready", 64'(ready), 64'd0);
      exp_busy++;
      busy_noise(1'b0);
      @(negedge clk);
    end
    for (int i = 0; i < SB; i++) begin
      check_val("rd_acc_r", 64'(acc_r), 64'd1);
      check_val("rd_acc_w", 64'(acc_w), 64'd0);
      check_val("rd_ready_burst", 64'(ready), 64'd0);
      check_val("rd_strobe", 64'(rd_strobe), 64'(i));
      check_val("rd_data", rd_data, model_mem[blk * SB + i]);
      exp_busy++;
      busy_noise(i == SB - 1);
      @(negedge clk);
    end
    hold_strobe = 2'(SB - 1);
    hold_data   = model_mem[blk * SB + SB - 1];
    check_val("rd_done_acc_r", 64'(acc_r), 64'd0);
    check_val("rd_done_strobe_hold", 64'(rd_strobe), 64'(hold_strobe));
    check_val("rd_done_data_hold", rd_data, hold_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wr_strobe = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    check_val("reset_ready", 64'(ready), 64'd1);
    check_val("reset_acc_r", 64'(acc_r), 64'd0);
    check_val("reset_acc_w", 64'(acc_w), 64'd0);
    check_val("reset_rd_strobe", 64'(rd_strobe), 64'd0);
    check_val("reset_rd_data", rd_data, 64'd0);

    // Directed full block at 0x40, then back-to-back read
    d = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
          64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    s = '{2'd0, 2'd1, 2'd2, 2'd3};
    do_write(32'h0000_0040, d, s);
    do_read(32'h0000_0040);

    // Pattern P at 0x80, then repeated/partial strobes 2,2,0,1
    for (int i = 0; i < SB; i++) d[i] = {$urandom, $urandom};
    s = '{2'd0, 2'd1, 2'd2, 2'd3};
    do_write(32'h0000_0080, d, s);
    for (int i = 0; i < SB; i++) d[i] = {$urandom, $urandom};
    s = '{2'd2, 2'd2, 2'd0, 2'd1};
    do_write(32'h0000_0080, d, s);
    do_read(32'h0000_0080);

    // Upper address bits wrap onto the same block
    do_read(32'h0000_0040 + (32'd1 << 17));

    // Reset during the read burst, right after beat 1
    en = 1'b1; we = 1'b0; addr = 32'h0000_0040;
    @(negedge clk);
    en = 1'b0;
    repeat (RL - 1) @(negedge clk);
    check_val("abort_rd_beat0", 64'(rd_strobe), 64'd0);
    @(negedge clk);
    check_val("abort_rd_beat1_acc", 64'(acc_r), 64'd1);
    check_val("abort_rd_beat1", 64'(rd_strobe), 64'd1);
    do_reset();
    check_val("abort_rd_ready", 64'(ready), 64'd1);
    check_val("abort_rd_acc_r", 64'(acc_r), 64'd0);
    check_val("abort_rd_strobe", 64'(rd_strobe), 64'd0);
    check_val("abort_rd_data", rd_data, 64'd0);

    // Reset after two write beats: those beats stay, the rest keep old data
    en = 1'b1; we = 1'b1; addr = 32'h0000_0040;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_strobe = 2'(i);
      wr_data   = {$urandom, $urandom};
      model_mem[2 * SB + i] = wr_data;
      @(negedge clk);
    end
    wr_strobe = 2'd2;
    wr_data   = 64'hDEAD_BEEF_DEAD_BEEF;
    do_reset();
    check_val("abort_wr_ready", 64'(ready), 64'd1);
    check_val("abort_wr_acc_w", 64'(acc_w), 64'd0);
    do_read(32'h0000_0040);

    // Fresh reset, one write plus one read for the statistics
    do_reset();
    for (int i = 0; i < SB; i++) d[i] = {$urandom, $urandom};
    s = '{2'd3, 2'd2, 2'd1, 2'd0};
    do_write(32'h0000_0100, d, s);
    do_read(32'h0000_0100);
`ifdef MEMD_STATS_EN
    check_val("stat_reads_one", 64'(stat_reads), 64'(exp_reads));
    check_val("stat_writes_one", 64'(stat_writes), 64'(exp_writes));
    check_val("stat_busy_one", 64'(stat_busy), 64'(exp_busy));
`endif

    // Randomized mix over a small set of blocks
    for (int b = 0; b < 6; b++) begin
      blks[b] = int'($urandom_range(0, 4095));
      for (int i = 0; i < SB; i++) begin
        d[i] = {$urandom, $urandom};
        s[i] = 2'(i);
      end
      do_write(addr_for(blks[b]), d, s);
    end
    for (int n = 0; n < 30; n++) begin
      int b;
      b = int'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < SB; i++) begin
          d[i] = {$urandom, $urandom};
          s[i] = 2'($urandom_range(0, 3));
        end
        do_write(addr_for(blks[b]), d, s);
      end else begin
        do_read(addr_for(blks[b]));
      end
    end

    check_val("final_ready", 64'(ready), 64'd1);
    check_val("final_acc_w", 64'(acc_w), 64'd0);
`ifdef MEMD_STATS_EN
    check_val("stat_reads_final", 64'(stat_reads), 64'(exp_reads));
    check_val("stat_writes_final", 64'(stat_writes), 64'(exp_writes));
    check_val("stat_busy_final", 64'(stat_busy), 64'(exp_busy));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dl2_backing_memory.md
Name: dl2_backing_memory

Overview:
Main-memory model and controller directly downstream of the unified L2 cache. It consumes L2 block fill and writeback requests on the D-side memory port and streams blocks as sub-block beats with programmable access latency. It holds a synthesizable block-addressed backing array and replaces the ad-hoc memory models in the system top.

Parameters:
ADDR_BITS, 32, byte-address width (matches DADDR_bits)
BLOCK_BITS, 256, L2 block size in bits
SUBBLOCKS, 4, beats per block; beat width = BLOCK_BITS/SUBBLOCKS
MEM_BLOCKS_LOG2, 12, log2 of number of blocks in the backing array
READ_LATENCY, 8, cycles from read acceptance to first beat (>=1)
WRITE_LATENCY, 4, commit cycles after last write beat before ready (>=0)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
addr  in  ADDR_BITS  request byte address; block offset bits ignored
en  in  1  request valid
we  in  1  1=writeback, 0=fill; sampled with en
wr_strobe  in  log2(SUBBLOCKS)  index of write beat presented
wr_data  in  BLOCK_BITS/SUBBLOCKS  write beat data
rd_strobe  out  log2(SUBBLOCKS)  index of read beat driven
rd_data  out  BLOCK_BITS/SUBBLOCKS  read beat data
ready  out  1  idle, able to accept a request
acc_r  out  1  read beat valid this cycle
acc_w  out  1  write beat sampled this cycle

Behaviour:
- One clock, clk; reset is synchronous and active-high; all state updates on posedge clk.
- Reset: state IDLE, ready=1, acc_r=0, acc_w=0, rd_strobe=0, rd_data=0, counters=0. Array contents are not cleared.
- Block index = addr[ADDR_BITS-1:log2(BLOCK_BITS/8)] modulo 2^MEM_BLOCKS_LOG2. Higher bits wrap silently.
- Acceptance: en=1 and ready=1 at an edge (cycle T). Address and we are latched and ready goes 0 at T+1. en while ready=0 is ignored, with no queuing.
- FSM states: IDLE, RLAT, RBURST, WBURST, WCOMMIT.
  - IDLE -> RLAT on accepted read. IDLE -> WBURST on accepted write.
  - RLAT counts READ_LATENCY-1 cycles, then RBURST.
  - RBURST: beats i=0..SUBBLOCKS-1 in consecutive cycles T+READ_LATENCY+i. Each beat drives acc_r=1, rd_strobe=i, rd_data=beat i of the latched block (beat 0 = least significant bits). Next state is IDLE and ready=1 at T+READ_LATENCY+SUBBLOCKS.
  - WBURST: acc_w=1 for cycles T+1..T+SUBBLOCKS. Each such cycle writes wr_data into beat wr_strobe of the latched block. A repeated strobe overwrites that beat; beats never presented keep their old data.
  - WCOMMIT holds for WRITE_LATENCY cycles, then IDLE. ready=1 at T+SUBBLOCKS+WRITE_LATENCY+1.
- rd_strobe and rd_data hold their last beat values when acc_r=0. acc_r and acc_w are never high together.
- A request on the same cycle ready returns to 1 is accepted, giving back-to-back operation. A read after a write to the same block returns the written data.
- Reset mid-operation aborts to IDLE on the next edge. Beats already written remain; a partial writeback is not rolled back.

Optional Feature:
MEMD_STATS_EN
- With the macro: adds outputs stat_reads [31:0], stat_writes [31:0], stat_busy [31:0].
  - stat_reads and stat_writes increment on each accepted read or write.
  - stat_busy increments every cycle ready=0.
  - All three saturate at 32'hFFFFFFFF and are cleared by reset.
- Without the macro: these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then idle 3 cycles -> ready=1, acc_r=0, acc_w=0, rd_strobe=0, rd_data=0.
- Write block at addr 0x40 with beats 0x11..,0x22..,0x33..,0x44.. (strobe 0..3) accepted at T -> acc_w high T+1..T+4; ready=1 at T+9.
- Read 0x40 accepted at T -> acc_r high T+8..T+11 with rd_strobe 0,1,2,3 and the written beats in order; ready=1 at T+12.
- Write with wr_strobe sequence 2,2,0,1 to a block holding pattern P -> later read returns beats 0,1 new, beat 2 = last value written, beat 3 = P's beat 3.
- Write addr 0x40, then read addr 0x40 + (1<<17) (wraps to the same index with defaults) -> same data. en pulsed during a busy read -> ignored, no extra acc_r.
- Reset asserted mid-RBURST after beat 1 -> next cycle ready=1, acc_r=0. With MEMD_STATS_EN: one read plus one write gives stat_reads=1, stat_writes=1, and stat_busy equal to the ready-low cycle count.
